// File: rtl/inv_mixcol_addkey_if.sv
// Handshake bundle for the inverse MixColumns / AddRoundKey stage.
// out_parity exists only when INV_MIXCOL_PARITY_EN is defined.
interface inv_mixcol_addkey_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_data;
    logic [0:127] in_key;
    logic         skip_mix;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_data;
`ifdef INV_MIXCOL_PARITY_EN
    logic [0:15]  out_parity;

    modport slave (
        input  in_valid, in_data, in_key, skip_mix, out_ready,
        output in_ready, out_valid, out_data, out_parity
    );
    modport master (
        output in_valid, in_data, in_key, skip_mix, out_ready,
        input  in_ready, out_valid, out_data, out_parity
    );
`else
    modport slave (
        input  in_valid, in_data, in_key, skip_mix, out_ready,
        output in_ready, out_valid, out_data
    );
    modport master (
        output in_valid, in_data, in_key, skip_mix, out_ready,
        input  in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/inv_mixcol_addkey.sv
// Decryption stage: AddRoundKey, then column-serial InvMixColumns (bypassed on the last round).
// Optional even-parity output per byte under INV_MIXCOL_PARITY_EN.

// One InvMixColumns column, built from xtime chains.
module inv_mixcol_col (
    input  logic [0:31] col_i,
    output logic [0:31] col_o
);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_byte
        logic [7:0] x2, x4, x8;
        assign a[k]  = col_i[8*k +: 8];
        assign x2    = xt(a[k]);
        assign x4    = xt(x2);
        assign x8    = xt(x4);
        assign m9[k] = x8 ^ a[k];
        assign mb[k] = x8 ^ x2 ^ a[k];
        assign md[k] = x8 ^ x4 ^ a[k];
        assign me[k] = x8 ^ x4 ^ x2;
    end

    assign col_o[0:7]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    assign col_o[8:15]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    assign col_o[16:23] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    assign col_o[24:31] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
endmodule

module inv_mixcol_addkey #(
    parameter int COLS_PER_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    inv_mixcol_addkey_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_e;

    localparam logic [1:0] STEP = 2'(COLS_PER_CYC);

    state_e       state_q, state_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic [0:127] st_q, st_d;
    logic [0:127] out_data_q;
    logic         load_out;

    logic [COLS_PER_CYC-1:0][1:0]  sel_col;
    logic [COLS_PER_CYC-1:0][31:0] col_in;
    logic [COLS_PER_CYC-1:0][31:0] col_out;

    for (genvar u = 0; u < COLS_PER_CYC; u++) begin : g_lane
        assign sel_col[u] = col_cnt_q + 2'(u);
        assign col_in[u]  = st_q[{sel_col[u], 5'b0} +: 32];
        inv_mixcol_col u_col (
            .col_i (col_in[u]),
            .col_o (col_out[u])
        );
    end

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        st_d      = st_q;
        load_out  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d = bus.in_data ^ bus.in_key;
                    if (bus.skip_mix) begin
                        state_d  = OUT;
                        load_out = 1'b1;
                    end else begin
                        col_cnt_d = 2'd0;
                        state_d   = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                for (int u = 0; u < COLS_PER_CYC; u++)
                    st_d[{sel_col[u], 5'b0} +: 32] = col_out[u];
                // Column 3 finishes on the group whose end reaches 4.
                if (({1'b0, col_cnt_q} + 3'(COLS_PER_CYC)) == 3'd4) begin
                    col_cnt_d = 2'd0;
                    state_d   = OUT;
                    load_out  = 1'b1;
                end else begin
                    col_cnt_d = col_cnt_q + STEP;
                end
            end
            OUT: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            col_cnt_q  <= 2'd0;
            st_q       <= '0;
            out_data_q <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            st_q      <= st_d;
            if (load_out)
                out_data_q <= st_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_data_q;

`ifdef INV_MIXCOL_PARITY_EN
    logic [0:15] parity_q, parity_d;

    always_comb begin
        parity_d = '0;
        for (int k = 0; k < 16; k++)
            parity_d[k] = ^st_d[8*k +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_q <= '0;
        else if (load_out)
            parity_q <= parity_d;
    end

    assign bus.out_parity = parity_q;
`endif
endmodule

// File: tb/tb_inv_mixcol_addkey.sv
// Bench: COLS_PER_CYC=1 and =4 instances share stimulus; a whole-state model checks both every cycle.
module tb_inv_mixcol_addkey;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [0:127] in_data = '0;
    logic [0:127] in_key = '0;
    logic         skip_mix = 1'b0;
    logic         out_ready = 1'b1;

    logic         rdy [2];
    logic         ov  [2];
    logic [0:127] od  [2];
`ifdef INV_MIXCOL_PARITY_EN
    logic [0:15]  par [2];
`endif

    int n_checks = 0;
    int n_err = 0;

    localparam logic [0:127] V1  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [0:127] V1E = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [0:127] V2  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [0:127] KF  = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    localparam logic [0:127] V2E = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [0:127] V3  = 128'h01234567_89abcdef_fedcba98_76543210;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [0:127] model(input logic [0:127] d, input logic [0:127] k, input logic skip);
        logic [7:0]   coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [0:127] s = d ^ k;
        logic [0:127] r = '0;
        logic [7:0]   acc;
        if (skip) return s;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(s[8*(4*c+j) +: 8], coef[(j - row + 4) % 4]);
                r[8*(4*c+row) +: 8] = acc;
            end
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int C = (g == 0) ? 1 : 4;
        inv_mixcol_addkey_if ifc ();

        assign ifc.in_valid  = in_valid;
        assign ifc.in_data   = in_data;
        assign ifc.in_key    = in_key;
        assign ifc.skip_mix  = skip_mix;
        assign ifc.out_ready = out_ready;
        assign rdy[g] = ifc.in_ready;
        assign ov[g]  = ifc.out_valid;
        assign od[g]  = ifc.out_data;
`ifdef INV_MIXCOL_PARITY_EN
        assign par[g] = ifc.out_parity;
`endif

        inv_mixcol_addkey #(.COLS_PER_CYC(C)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );

        // phase: 0 waiting for input, 1 transforming, 2 presenting result
        int           phase = 0;
        int           cnt = 0;
        logic [0:127] m_exp = '0;
        logic [0:127] m_out = '0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                phase = 0;
                m_out = '0;
            end else begin
                case (phase)
                    0: if (in_valid) begin
                        m_exp = model(in_data, in_key, skip_mix);
                        if (skip_mix) begin
                            phase = 2;
                            m_out = m_exp;
                        end else begin
                            phase = 1;
                            cnt = 4 / C;
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            phase = 2;
                            m_out = m_exp;
                        end
                    end
                    default: if (out_ready) phase = 0;
                endcase
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                check($sformatf("dut%0d in_ready", g), 128'(ifc.in_ready), 128'(phase == 0));
                check($sformatf("dut%0d out_valid", g), 128'(ifc.out_valid), 128'(phase == 2));
                check($sformatf("dut%0d out_data", g), ifc.out_data, m_out);
`ifdef INV_MIXCOL_PARITY_EN
                for (int k = 0; k < 16; k++)
                    check($sformatf("dut%0d parity%0d", g, k), 128'(ifc.out_parity[k]), 128'(^m_out[8*k +: 8]));
`endif
            end
        end
    end

    // Offers one transaction to the COLS_PER_CYC=1 instance and measures edges to out_valid.
    task automatic send(input logic [0:127] d, input logic [0:127] k, input logic s, output int lat);
        int t = 0;
        @(negedge clk);
        in_data = d; in_key = k; skip_mix = s; in_valid = 1'b1;
        while (!rdy[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) check("accept timeout", 128'(rdy[0]), 128'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!ov[0] && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [0:127] vd [3] = '{V3, V2, V1};
        logic [0:127] vk [3] = '{KF, V3, V2};
        logic         vs [3] = '{1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("reset in_ready%0d", g), 128'(rdy[g]), 128'd1);
            check($sformatf("reset out_valid%0d", g), 128'(ov[g]), 128'd0);
            check($sformatf("reset out_data%0d", g), od[g], 128'd0);
        end
        check("model pin mix", model(V1, '0, 1'b0), V1E);
        check("model pin skip", model(V2, KF, 1'b1), V2E);

        // Mix path, default columns per cycle
        send(V1, '0, 1'b0, lat);
        check("mix latency", 128'(lat), 128'd5);
        check("mix data", od[0], V1E);
        @(posedge clk);
        #1 check("mix pulse width", 128'(ov[0]), 128'd0);
        check("cols4 data", od[1], V1E);
`ifdef INV_MIXCOL_PARITY_EN
        check("cols4 parity byte0", 128'(par[1][0]), 128'd0);
        check("cols4 parity byte8", 128'(par[1][8]), 128'd1);
`endif

        // AddRoundKey + skip, held under backpressure
        out_ready = 1'b0;
        send(V2, KF, 1'b1, lat);
        check("skip latency", 128'(lat), 128'd1);
        check("skip data", od[0], V2E);
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = V3; skip_mix = 1'b0;
            check("bp out_valid", 128'(ov[0]), 128'd1);
            check("bp in_ready", 128'(rdy[0]), 128'd0);
            check("bp out_data", od[0], V2E);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 check("bp handoff out_valid", 128'(ov[0]), 128'd0);
        check("bp handoff in_ready", 128'(rdy[0]), 128'd1);
        check("bp held out_data", od[0], V2E);

        // Reset in the middle of COMPUTE (col_cnt=2)
        @(negedge clk);
        in_data = V1; in_key = '0; skip_mix = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        #1;
        check("rst out_valid", 128'(ov[0]), 128'd0);
        check("rst out_data", od[0], 128'd0);
        check("rst in_ready", 128'(rdy[0]), 128'd1);
        send(V1, '0, 1'b0, lat);
        check("post-rst latency", 128'(lat), 128'd5);
        check("post-rst data", od[0], V1E);

        // Keyed vectors, result from the model
        for (int i = 0; i < 3; i++) begin
            send(vd[i], vk[i], vs[i], lat);
            check($sformatf("vec%0d latency", i), 128'(lat), vs[i] ? 128'd1 : 128'd5);
            check($sformatf("vec%0d data", i), od[0], model(vd[i], vk[i], vs[i]));
        end

        repeat (8) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
